fc_argmax: RTL and testbench

- Classifier stage directly downstream of the ten fully-connected neuron blocks (w_fc0..w_fc9).
- Waits until every neuron's done flag is set, then registers all ten signed 38-bit scores in one cycle.
- Scans the registered scores sequentially, one comparison per cycle, and reports the winning class index and its score.
- Uses the same level-sensitive enable protocol as the FC stage, so it sits directly on the existing FC outputs.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/fc_argmax.sv | 89 ++++++++
 tb/tb_fc_argmax.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN classifier types and default sizes.
// fc_argmax imports this package for its widths and FSM state type.
package cnn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int ACC_W       = 38;
  localparam int IDX_W       = 4;

  typedef logic signed [ACC_W-1:0] score_t;
  typedef logic [IDX_W-1:0]        cls_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } fc_argmax_state_e;
endpackage

// File: rtl/fc_argmax.sv
// Argmax over the FC neuron scores: snapshot all scores once every neuron is done,
// then walk them one per cycle keeping the first strictly-largest entry.
module fc_argmax #(
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
  parameter int ACC_W       = cnn_pkg::ACC_W,
  parameter int IDX_W       = cnn_pkg::IDX_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_CLASSES*ACC_W-1:0] fc_in,
  input  logic [NUM_CLASSES-1:0]       done_fc,
  output logic [IDX_W-1:0]             class_idx,
  output logic [ACC_W-1:0]             max_val,
  output logic                         busy,
  output logic                         done_cls
);
  import cnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  fc_argmax_state_e        state;
  logic signed [ACC_W-1:0] scores [NUM_CLASSES];
  logic signed [ACC_W-1:0] best;
  logic [IDX_W-1:0]        best_idx;
  logic [IDX_W-1:0]        idx;

  logic signed [ACC_W-1:0] cur;
  logic signed [ACC_W-1:0] nxt_best;
  logic [IDX_W-1:0]        nxt_best_idx;

  // Strict > keeps the earlier index on ties.
  always_comb begin
    cur          = scores[idx];
    nxt_best     = best;
    nxt_best_idx = best_idx;
    if (cur > best) begin
      nxt_best     = cur;
      nxt_best_idx = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      class_idx <= '0;
      max_val   <= '0;
      busy      <= 1'b0;
      done_cls  <= 1'b0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) scores[k] <= '0;
    end else if (!enable) begin
      state     <= IDLE;
      class_idx <= '0;
      max_val   <= '0;
      busy      <= 1'b0;
      done_cls  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (&done_fc) begin
            for (int k = 0; k < NUM_CLASSES; k++) scores[k] <= fc_in[k*ACC_W +: ACC_W];
            best     <= fc_in[ACC_W-1:0];
            best_idx <= '0;
            idx      <= IDX_W'(1);
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= nxt_best;
          best_idx <= nxt_best_idx;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            class_idx <= nxt_best_idx;
            max_val   <= nxt_best;
            done_cls  <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_argmax.sv
// Randomized and directed checks of fc_argmax against a plain argmax model.
module tb_fc_argmax;
  localparam int NC = 10;
  localparam int AW = 38;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NC*AW-1:0] fc_in;
  logic [NC-1:0]    done_fc;
  logic [IW-1:0]    class_idx;
  logic [AW-1:0]    max_val;
  logic             busy;
  logic             done_cls;

  int total = 0;
  int bad   = 0;
  longint sc [NC];

  fc_argmax dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fc_in(fc_in), .done_fc(done_fc),
    .class_idx(class_idx), .max_val(max_val), .busy(busy), .done_cls(done_cls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint rnd_score();
    logic [AW-1:0] r;
    r = AW'({$urandom(), $urandom()});
    return longint'($signed(r));
  endfunction

  task automatic load();
    for (int k = 0; k < NC; k++) begin
      logic [63:0] v;
      v = sc[k];
      fc_in[k*AW +: AW] = v[AW-1:0];
    end
  endtask

  function automatic longint mval(); return longint'($signed(max_val)); endfunction

  task automatic chk_clear(input string tag);
    chk({tag, "_idx"},  class_idx, 0);
    chk({tag, "_max"},  mval(), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done_cls, 0);
  endtask

  // Assumes scores are loaded and the block is idle; the next edge is the start edge.
  task automatic run_scan(input string tag, input bit drop_done);
    longint bv;
    int     bi;
    bv = sc[0];
    bi = 0;
    for (int k = 1; k < NC; k++) if (sc[k] > bv) begin bv = sc[k]; bi = k; end
    enable  = 1'b1;
    done_fc = '1;
    step();
    for (int i = 0; i < NC - 1; i++) begin
      chk({tag, "_busy_scan"}, busy, 1);
      chk({tag, "_done_scan"}, done_cls, 0);
      if (i == 2) begin
        for (int k = 0; k < NC; k++) sc[k] = rnd_score();
        load();
        if (drop_done) done_fc = '0;
      end
      step();
    end
    chk({tag, "_done"}, done_cls, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"},  class_idx, bi);
    chk({tag, "_max"},  mval(), bv);
    done_fc = '1;
    step();
    step();
    chk({tag, "_hold_done"}, done_cls, 1);
    chk({tag, "_hold_idx"},  class_idx, bi);
    chk({tag, "_hold_max"},  mval(), bv);
    enable = 1'b0;
    step();
    chk_clear({tag, "_clr"});
  endtask

  initial begin
    longint lo;
    lo = -(longint'(1) <<< (AW - 1));
    rst_n = 1'b0; enable = 1'b0; done_fc = '0; fc_in = '0;
    step(); step();
    chk_clear("reset");
    rst_n = 1'b1;
    step();

    // Clear winner at index 7.
    for (int k = 0; k < NC; k++) sc[k] = longint'(k * 400);
    sc[7] = 5000;
    load();
    run_scan("dist", 1'b0);

    // Tie between 2 and 5.
    for (int k = 0; k < NC; k++) sc[k] = 0;
    sc[2] = 123456; sc[5] = 123456;
    load();
    run_scan("tie", 1'b0);

    // Most negative everywhere except last.
    for (int k = 0; k < NC; k++) sc[k] = lo;
    sc[9] = -1;
    load();
    run_scan("neg", 1'b1);

    // Most positive at index 0.
    for (int k = 0; k < NC; k++) sc[k] = -longint'(k + 1) * 1000;
    sc[0] = -lo - 1;
    load();
    run_scan("pos", 1'b0);

    // Partial handshake: no capture until the last neuron reports.
    for (int k = 0; k < NC; k++) sc[k] = rnd_score();
    load();
    enable = 1'b1; done_fc = 10'h1FF;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 5 == 4) begin
        chk("partial_busy", busy, 0);
        chk("partial_done", done_cls, 0);
      end
    end
    run_scan("partial", 1'b0);

    // Abort mid-scan, then restart with the maximum at index 3.
    for (int k = 0; k < NC; k++) sc[k] = rnd_score();
    load();
    enable = 1'b1; done_fc = '1;
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0;
    step();
    chk_clear("abort");
    for (int k = 0; k < NC; k++) sc[k] = longint'($urandom_range(0, 9999)) - 5000;
    sc[3] = 20000;
    load();
    run_scan("restart", 1'b0);

    // Synchronous reset mid-scan wins over enable.
    for (int k = 0; k < NC; k++) sc[k] = rnd_score();
    load();
    enable = 1'b1; done_fc = '1;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    chk_clear("rst_mid");
    rst_n = 1'b1;
    for (int k = 0; k < NC; k++) sc[k] = rnd_score();
    load();
    run_scan("post_rst", 1'b0);

    // Random sweeps; narrow ranges provoke ties.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < NC; k++)
        sc[k] = (t % 2 == 0) ? rnd_score() : longint'($urandom_range(0, 3)) - 2;
      load();
      run_scan($sformatf("rnd%0d", t), t % 3 == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
